cprv_regfile_mp: RTL and testbench
==================================

Name: cprv_regfile_mp

Overview:
Parametrised multi-port integer register file for the cprv64g core, successor to the single-write/dual-read file. Adds configurable read and write port counts, hardwired x0, optional write-to-read bypass, a per-register pending-write scoreboard, and a post-reset sequential clear engine. Sits between decode/issue (reads, scoreboard set) and writeback (writes, scoreboard clear).

Parameters:
DATA_WIDTH, 64, register width in bits
REGADDR_WIDTH, 5, address width; depth NREGS = 2**REGADDR_WIDTH
NUM_RD, 2, number of read ports (1..4)
NUM_WR, 1, number of write ports (1..2)
BYPASS, 1, 1 = a same-cycle write is forwarded to matching reads

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
init_done  out  1  high once the clear sequence has finished
rs_addr  in  NUM_RD*REGADDR_WIDTH  read addresses; port i at slice i
rs_data  out  NUM_RD*DATA_WIDTH  read data, combinational
rs_busy  out  NUM_RD  scoreboard bit for each read address
wr_en  in  NUM_WR  write enables
wr_addr  in  NUM_WR*REGADDR_WIDTH  write addresses
wr_data  in  NUM_WR*DATA_WIDTH  write data
sb_set_en  in  1  issue marks sb_set_addr as pending
sb_set_addr  in  REGADDR_WIDTH  destination register being issued
sb_flush  in  1  clear every scoreboard bit (pipeline flush)

Behaviour:
- Reset (async assert): FSM -> CLEAR, clear counter = 1, all busy bits = 0, init_done = 0. Reset asserted mid-CLEAR or in READY restarts the sequence.
- FSM CLEAR: each cycle writes 0 to mem[counter], counter++. At counter == NREGS-1 that write happens, then -> READY on the next edge. init_done = 1 in READY only. Clearing registers 1..NREGS-1 takes exactly NREGS-1 cycles after reset deassertion.
- In CLEAR: wr_en, sb_set_en and sb_flush are ignored; rs_data = 0; rs_busy = 0.
- Reads are combinational with zero latency. Address 0 always returns 0 and busy 0.
- Writes take effect at the clock edge. Writes to address 0 are dropped.
- Same-address writes from two ports in one cycle: the higher port index wins.
- BYPASS=1: when a read address matches an enabled write (non-zero address), rs_data returns that wr_data in the same cycle, with the highest matching port winning. BYPASS=0: a read returns the old value until the edge.
- Scoreboard: an enabled write clears busy[wr_addr] at the edge. sb_set_en sets busy[sb_set_addr].
- Set and clear of the same address in one cycle: set wins, because the new producer is younger.
- sb_flush clears all busy bits and takes priority over a same-cycle set. It does not block same-cycle data writes.
- Scoreboard set on address 0 is ignored.
- rs_busy reflects the registered busy state. There is no bypass of set or clear onto rs_busy.

Decomposition:
- Package cprv_regfile_pkg: regfile FSM enum (CLEAR, READY) and localparam NREGS.
- One sub-module, cprv_regfile_sb: the scoreboard bit vector with set/clear/flush priority logic.
- Storage, clear engine and bypass muxing live in the top.

Test Plan:
- Reset release -> init_done low for exactly 31 cycles then high; reads of x1..x31 return 0 and rs_busy = 0.
- Write x5 = 0xDEAD_BEEF_0123_4567 with BYPASS=1 -> rs_data of port 0 (addr 5) shows the value in the same cycle. Repeat with BYPASS=0 -> value appears only after the edge.
- Write x0 = 0xFFFF... -> read x0 returns 0; rs_busy stays 0 after sb_set_en on address 0.
- NUM_WR=2, both ports write x7 (0x1 on port 0, 0x2 on port 1) -> x7 = 0x2, and the bypassed read shows 0x2.
- sb_set_en x9, then a write to x9 with a concurrent sb_set_en x9 -> busy stays 1. Next cycle sb_flush together with sb_set x9 -> busy 0.
- Assert rst at clear counter 12 -> init_done stays 0 and the full 31-cycle clear restarts. Writes issued during CLEAR have no effect.

Source files
------------

// File: rtl/cprv_regfile_mp_pkg.sv
// Shared types and constants for the cprv64g multi-port integer register file.
package cprv_regfile_pkg;

   // Default address width and depth of the architectural integer file.
   localparam int REGADDR_WIDTH_DEF = 5;
   localparam int NREGS             = 2 ** REGADDR_WIDTH_DEF;

   // CLEAR: post-reset zeroing sweep in progress; READY: normal operation.
   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      READY = 1'b1
   } rf_state_e;

endpackage

// File: rtl/cprv_regfile_mp_if.sv
// Issue/writeback-facing bus of the multi-port register file.
// master = decode/issue/writeback side, slave = the register file.
interface cprv_regfile_mp_if #(
   parameter int DATA_WIDTH    = 64,
   parameter int REGADDR_WIDTH = 5,
   parameter int NUM_RD        = 2,
   parameter int NUM_WR        = 1
);
   logic                                    init_done;
   logic [NUM_RD-1:0][REGADDR_WIDTH-1:0]    rs_addr;
   logic [NUM_RD-1:0][DATA_WIDTH-1:0]       rs_data;
   logic [NUM_RD-1:0]                       rs_busy;
   logic [NUM_WR-1:0]                       wr_en;
   logic [NUM_WR-1:0][REGADDR_WIDTH-1:0]    wr_addr;
   logic [NUM_WR-1:0][DATA_WIDTH-1:0]       wr_data;
   logic                                    sb_set_en;
   logic [REGADDR_WIDTH-1:0]                sb_set_addr;
   logic                                    sb_flush;

   modport master (
      input  init_done, rs_data, rs_busy,
      output rs_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr, sb_flush
   );

   modport slave (
      output init_done, rs_data, rs_busy,
      input  rs_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr, sb_flush
   );
endinterface

// File: rtl/cprv_regfile_mp_sb.sv
// Pending-write scoreboard: one busy bit per register.
// Priority within a cycle (lowest to highest): writeback clear, issue set, flush.
module cprv_regfile_sb #(
   parameter int NREGS         = cprv_regfile_pkg::NREGS,
   parameter int REGADDR_WIDTH = cprv_regfile_pkg::REGADDR_WIDTH_DEF,
   parameter int NUM_WR        = 1
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 en_i,
   input  logic                                 set_en_i,
   input  logic [REGADDR_WIDTH-1:0]             set_addr_i,
   input  logic [NUM_WR-1:0]                    clr_en_i,
   input  logic [NUM_WR-1:0][REGADDR_WIDTH-1:0] clr_addr_i,
   input  logic                                 flush_i,
   output logic [NREGS-1:0]                     busy_o
);

   logic [NREGS-1:0] busy_q, busy_d;

   // Next busy vector; a set beats a same-cycle clear because the newly
   // issued producer is younger than the one writing back.
   always_comb begin
      busy_d = busy_q;
      if (en_i) begin
         for (int j = 0; j < NUM_WR; j++) begin
            if (clr_en_i[j]) busy_d[clr_addr_i[j]] = 1'b0;
         end
         if (set_en_i) busy_d[set_addr_i] = 1'b1;
         if (flush_i)  busy_d = '0;
      end
      busy_d[0] = 1'b0;   // x0 never has a pending producer
   end

   // Busy register, cleared by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) busy_q <= '0;
      else     busy_q <= busy_d;
   end

   assign busy_o = busy_q;

endmodule

// File: rtl/cprv_regfile_mp.sv
// Parametrised multi-port integer register file with hardwired x0,
// optional write-to-read bypass, pending-write scoreboard and a
// post-reset sequential clear engine.
module cprv_regfile_mp
   import cprv_regfile_pkg::*;
#(
   parameter int DATA_WIDTH    = 64,
   parameter int REGADDR_WIDTH = 5,
   parameter int NUM_RD        = 2,
   parameter int NUM_WR        = 1,
   parameter int BYPASS        = 1
) (
   input  logic             clk,
   input  logic             rst,
   cprv_regfile_mp_if.slave bus_if
);

   localparam int                       DEPTH = 2 ** REGADDR_WIDTH;
   localparam logic [REGADDR_WIDTH-1:0] LAST  = REGADDR_WIDTH'(DEPTH - 1);
   localparam logic [REGADDR_WIDTH-1:0] ONE   = REGADDR_WIDTH'(1);

   rf_state_e                          state_q, state_d;
   logic [REGADDR_WIDTH-1:0]           cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]              mem_q [DEPTH];
   logic                               ready;
   logic [DEPTH-1:0]                   busy;
   logic [NUM_RD-1:0][DATA_WIDTH-1:0]  rd_data;
   logic [NUM_RD-1:0]                  rd_busy;

   // Clear engine: sweep x1..x(DEPTH-1), leaving for READY on the edge
   // that zeroes the last register.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == CLEAR) begin
         cnt_d = cnt_q + ONE;
         if (cnt_q == LAST) state_d = READY;
      end
   end

   // FSM and sweep counter; any reset restarts the sweep from x1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= CLEAR;
         cnt_q   <= ONE;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ready            = (state_q == READY);
   assign bus_if.init_done = ready;

   // Storage: sweep writes in CLEAR, port writes in READY. Ports are
   // visited in ascending order so the highest index wins a collision.
   // x0 is never written; reads of it are forced to zero below.
   always_ff @(posedge clk) begin
      if (!ready) begin
         mem_q[cnt_q] <= '0;
      end else begin
         for (int j = 0; j < NUM_WR; j++) begin
            if (bus_if.wr_en[j] && (bus_if.wr_addr[j] != '0))
               mem_q[bus_if.wr_addr[j]] <= bus_if.wr_data[j];
         end
      end
   end

   // Combinational read ports with optional same-cycle forwarding;
   // everything reads as zero / not busy until the sweep is done.
   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         if (ready && (bus_if.rs_addr[i] != '0)) begin
            rd_data[i] = mem_q[bus_if.rs_addr[i]];
            rd_busy[i] = busy[bus_if.rs_addr[i]];
            if (BYPASS != 0) begin
               for (int j = 0; j < NUM_WR; j++) begin
                  if (bus_if.wr_en[j] && (bus_if.wr_addr[j] == bus_if.rs_addr[i]))
                     rd_data[i] = bus_if.wr_data[j];
               end
            end
         end
      end
   end

   assign bus_if.rs_data = rd_data;
   assign bus_if.rs_busy = rd_busy;

   cprv_regfile_sb #(
      .NREGS         (DEPTH),
      .REGADDR_WIDTH (REGADDR_WIDTH),
      .NUM_WR        (NUM_WR)
   ) u_sb (
      .clk        (clk),
      .rst        (rst),
      .en_i       (ready),
      .set_en_i   (bus_if.sb_set_en),
      .set_addr_i (bus_if.sb_set_addr),
      .clr_en_i   (bus_if.wr_en),
      .clr_addr_i (bus_if.wr_addr),
      .flush_i    (bus_if.sb_flush),
      .busy_o     (busy)
   );

endmodule

// File: tb/tb_cprv_regfile_mp.sv
// Directed bench for cprv_regfile_mp: dut_a = 2 write ports with bypass,
// dut_b = 1 write port without bypass, both on a shared clock and reset.
module tb_cprv_regfile_mp;

   localparam int DW = 64;
   localparam int AW = 5;
   localparam int NR = 2;
   localparam logic [63:0] DEAD = 64'hDEAD_BEEF_0123_4567;

   logic clk = 1'b0;
   logic rst;
   int   n_chk, n_fail;
   int   cyc_a, cyc_b;
   logic [63:0] acc;

   always #5 clk = ~clk;

   cprv_regfile_mp_if #(.DATA_WIDTH(DW), .REGADDR_WIDTH(AW), .NUM_RD(NR), .NUM_WR(2)) ifa ();
   cprv_regfile_mp_if #(.DATA_WIDTH(DW), .REGADDR_WIDTH(AW), .NUM_RD(NR), .NUM_WR(1)) ifb ();

   cprv_regfile_mp #(.DATA_WIDTH(DW), .REGADDR_WIDTH(AW), .NUM_RD(NR), .NUM_WR(2), .BYPASS(1))
      dut_a (.clk(clk), .rst(rst), .bus_if(ifa));
   cprv_regfile_mp #(.DATA_WIDTH(DW), .REGADDR_WIDTH(AW), .NUM_RD(NR), .NUM_WR(1), .BYPASS(0))
      dut_b (.clk(clk), .rst(rst), .bus_if(ifb));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ifa.wr_en = '0; ifa.wr_addr = '0; ifa.wr_data = '0;
      ifa.sb_set_en = 1'b0; ifa.sb_set_addr = '0; ifa.sb_flush = 1'b0;
      ifb.wr_en = '0; ifb.wr_addr = '0; ifb.wr_data = '0;
      ifb.sb_set_en = 1'b0; ifb.sb_set_addr = '0; ifb.sb_flush = 1'b0;
   endtask

   task automatic set_both(input logic [AW-1:0] a);
      ifa.sb_set_en = 1'b1; ifa.sb_set_addr = a;
      ifb.sb_set_en = 1'b1; ifb.sb_set_addr = a;
   endtask

   // Count edges after reset release until each init_done rises (bounded).
   task automatic wait_ready(output int ca, output int cb);
      int c;
      c = 0; ca = 999; cb = 999;
      while ((ifa.init_done !== 1'b1 || ifb.init_done !== 1'b1) && c < 100) begin
         tick();
         c++;
         if (ifa.init_done === 1'b1 && ca == 999) ca = c;
         if (ifb.init_done === 1'b1 && cb == 999) cb = c;
      end
   endtask

   initial begin
      n_chk = 0; n_fail = 0;
      rst = 1'b0;
      idle();
      ifa.rs_addr = '0; ifb.rs_addr = '0;
      #2 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_init_done_a", ifa.init_done, 1'b0);
      chk("rst_init_done_b", ifb.init_done, 1'b0);

      // Writes and scoreboard sets held through the whole clear phase.
      ifa.wr_en = 2'b01; ifa.wr_addr[0] = 5'd3; ifa.wr_data[0] = 64'hAAAA_AAAA_AAAA_AAAA;
      ifb.wr_en = 1'b1;  ifb.wr_addr[0] = 5'd3; ifb.wr_data[0] = 64'hAAAA_AAAA_AAAA_AAAA;
      set_both(5'd3);
      ifa.rs_addr[0] = 5'd3; ifb.rs_addr[0] = 5'd3;
      rst = 1'b0;
      repeat (11) tick();            // sweep counter now at 12
      chk("clear_bypass_blocked_a", ifa.rs_data[0], 64'h0);
      chk("clear_busy_a", ifa.rs_busy[0], 1'b0);
      chk("clear_init_low_a", ifa.init_done, 1'b0);
      rst = 1'b1;
      #1;
      chk("midclear_rst_init_low_a", ifa.init_done, 1'b0);
      tick(); tick();
      rst = 1'b0;
      wait_ready(cyc_a, cyc_b);
      idle();
      chk("init_cycles_a", cyc_a, 31);
      chk("init_cycles_b", cyc_b, 31);
      #1;
      chk("clear_ignored_wr_x3_a", ifa.rs_data[0], 64'h0);
      chk("clear_ignored_wr_x3_b", ifb.rs_data[0], 64'h0);
      chk("clear_ignored_set_x3_a", ifa.rs_busy[0], 1'b0);

      // Every register reads zero and not busy after the sweep.
      acc = '0;
      for (int r = 1; r < 32; r++) begin
         ifa.rs_addr[0] = AW'(r); ifa.rs_addr[1] = AW'(32 - r);
         ifb.rs_addr[0] = AW'(r); ifb.rs_addr[1] = AW'(32 - r);
         #1;
         acc = acc | ifa.rs_data[0] | ifa.rs_data[1] | ifb.rs_data[0] | ifb.rs_data[1]
                   | 64'(ifa.rs_busy) | 64'(ifb.rs_busy);
      end
      chk("all_regs_zero", acc, 64'h0);

      // Same-cycle bypass vs. write-at-edge.
      ifa.wr_en = 2'b01; ifa.wr_addr[0] = 5'd5; ifa.wr_data[0] = DEAD;
      ifb.wr_en = 1'b1;  ifb.wr_addr[0] = 5'd5; ifb.wr_data[0] = DEAD;
      ifa.rs_addr[0] = 5'd5; ifb.rs_addr[0] = 5'd5;
      #1;
      chk("bypass_same_cycle_a", ifa.rs_data[0], DEAD);
      chk("nobypass_old_b", ifb.rs_data[0], 64'h0);
      tick(); idle(); #1;
      chk("x5_stored_a", ifa.rs_data[0], DEAD);
      chk("x5_stored_b", ifb.rs_data[0], DEAD);

      // x0 is hardwired: writes, bypass and scoreboard sets are ignored.
      ifa.wr_en = 2'b01; ifa.wr_addr[0] = 5'd0; ifa.wr_data[0] = '1;
      ifb.wr_en = 1'b1;  ifb.wr_addr[0] = 5'd0; ifb.wr_data[0] = '1;
      set_both(5'd0);
      ifa.rs_addr[0] = 5'd0; ifb.rs_addr[0] = 5'd0;
      #1;
      chk("x0_no_bypass_a", ifa.rs_data[0], 64'h0);
      tick(); idle(); #1;
      chk("x0_read_a", ifa.rs_data[0], 64'h0);
      chk("x0_read_b", ifb.rs_data[0], 64'h0);
      chk("x0_busy_a", ifa.rs_busy[0], 1'b0);
      chk("x0_busy_b", ifb.rs_busy[0], 1'b0);

      // Two ports hit x7: port 1 wins in storage and in the bypass.
      ifa.wr_en = 2'b11;
      ifa.wr_addr[0] = 5'd7; ifa.wr_data[0] = 64'h1;
      ifa.wr_addr[1] = 5'd7; ifa.wr_data[1] = 64'h2;
      ifa.rs_addr[1] = 5'd7; ifb.rs_addr[1] = 5'd7;
      #1;
      chk("dual_wr_bypass_a", ifa.rs_data[1], 64'h2);
      tick(); idle(); #1;
      chk("dual_wr_stored_a", ifa.rs_data[1], 64'h2);
      chk("x7_untouched_b", ifb.rs_data[1], 64'h0);

      // Scoreboard set is registered; set beats a same-cycle writeback clear.
      set_both(5'd9);
      ifa.rs_addr[0] = 5'd9; ifb.rs_addr[0] = 5'd9;
      #1;
      chk("set_not_bypassed_a", ifa.rs_busy[0], 1'b0);
      tick(); idle(); #1;
      chk("set_x9_a", ifa.rs_busy[0], 1'b1);
      chk("set_x9_b", ifb.rs_busy[0], 1'b1);
      ifa.wr_en = 2'b01; ifa.wr_addr[0] = 5'd9; ifa.wr_data[0] = 64'h99;
      ifb.wr_en = 1'b1;  ifb.wr_addr[0] = 5'd9; ifb.wr_data[0] = 64'h99;
      set_both(5'd9);
      tick(); idle(); #1;
      chk("set_beats_clr_a", ifa.rs_busy[0], 1'b1);
      chk("set_beats_clr_b", ifb.rs_busy[0], 1'b1);
      chk("x9_data_a", ifa.rs_data[0], 64'h99);

      // Flush beats a same-cycle set and does not block data writes.
      set_both(5'd9);
      ifa.sb_flush = 1'b1; ifb.sb_flush = 1'b1;
      ifa.wr_en = 2'b01; ifa.wr_addr[0] = 5'd10; ifa.wr_data[0] = 64'h1010;
      ifb.wr_en = 1'b1;  ifb.wr_addr[0] = 5'd10; ifb.wr_data[0] = 64'h1010;
      ifa.rs_addr[1] = 5'd10; ifb.rs_addr[1] = 5'd10;
      tick(); idle(); #1;
      chk("flush_beats_set_a", ifa.rs_busy[0], 1'b0);
      chk("flush_beats_set_b", ifb.rs_busy[0], 1'b0);
      chk("flush_keeps_wr_a", ifa.rs_data[1], 64'h1010);
      chk("flush_keeps_wr_b", ifb.rs_data[1], 64'h1010);

      // A plain writeback clears busy, including via write port 1.
      set_both(5'd11);
      ifa.rs_addr[0] = 5'd11; ifb.rs_addr[0] = 5'd11;
      tick(); idle(); #1;
      chk("set_x11_a", ifa.rs_busy[0], 1'b1);
      ifa.wr_en = 2'b10; ifa.wr_addr[1] = 5'd11; ifa.wr_data[1] = 64'hB;
      ifb.wr_en = 1'b1;  ifb.wr_addr[0] = 5'd11; ifb.wr_data[0] = 64'hB;
      tick(); idle(); #1;
      chk("wb_clr_port1_a", ifa.rs_busy[0], 1'b0);
      chk("wb_clr_b", ifb.rs_busy[0], 1'b0);
      chk("x11_port1_data_a", ifa.rs_data[0], 64'hB);

      // Busy visible on read port 1, then a reset from READY restarts the sweep.
      set_both(5'd12);
      ifa.rs_addr[1] = 5'd12; ifb.rs_addr[1] = 5'd12;
      ifa.rs_addr[0] = 5'd5;  ifb.rs_addr[0] = 5'd5;
      tick(); idle(); #1;
      chk("busy_port1_a", ifa.rs_busy[1], 1'b1);
      rst = 1'b1;
      #1;
      chk("ready_rst_init_low_a", ifa.init_done, 1'b0);
      chk("ready_rst_busy_a", ifa.rs_busy[1], 1'b0);
      tick();
      rst = 1'b0;
      wait_ready(cyc_a, cyc_b);
      chk("reinit_cycles_a", cyc_a, 31);
      chk("reinit_busy_x12_a", ifa.rs_busy[1], 1'b0);
      chk("reinit_x5_zero_a", ifa.rs_data[0], 64'h0);
      chk("reinit_x5_zero_b", ifb.rs_data[0], 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
